// File: rtl/i2s_transmitter.sv
// I2S transmitter: divides the system clock down to BCLK/LRCLK and shifts stereo
// PCM frames out MSB first with the standard one-bit word-select delay.
`timescale 1ns/1ps

module i2s_transmitter #(
    parameter int CLK_DIV      = 49,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] i_left,
    input  logic signed [SAMPLE_WIDTH-1:0] i_right,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic                           o_bclk,
    output logic                           o_lrclk,
    output logic                           o_din,
    output logic                           o_underrun
);

    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int SLOT_W  = $clog2(FRAME_W);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               bclk_q, bclk_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               lrclk_q, lrclk_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               und_q, und_d;
    logic               full_q, full_d;

    logic signed [SAMPLE_WIDTH-1:0] buf_l_q;
    logic signed [SAMPLE_WIDTH-1:0] buf_r_q;

    logic               tick;
    logic               fall_tick;
    logic               load;
    logic               bypass;
    logic               accept;
    logic [FRAME_W-1:0] load_src;

    always_comb begin
        tick      = (div_q == DIV_W'(CLK_DIV - 1));
        fall_tick = tick && bclk_q;
        load      = fall_tick && (slot_q == '0);
        bypass    = load && !full_q && i_valid;
        accept    = i_valid && !full_q && !bypass;

        // Buffered pair wins over the live inputs; silence when neither exists.
        if (full_q) begin
            load_src = {buf_l_q, buf_r_q};
        end else if (i_valid) begin
            load_src = {i_left, i_right};
        end else begin
            load_src = '0;
        end
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        bclk_d  = tick ? ~bclk_q : bclk_q;
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        shift_d = shift_q;
        und_d   = 1'b0;
        full_d  = full_q;

        if (fall_tick) begin
            slot_d  = (slot_q == SLOT_W'(FRAME_W - 1)) ? '0 : slot_q + 1'b1;
            lrclk_d = (slot_d >= SLOT_W'(SAMPLE_WIDTH));
            if (load) begin
                shift_d = load_src;
                und_d   = !full_q && !i_valid;
                if (full_q) begin
                    full_d = 1'b0;
                end
            end else begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end

        if (accept) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= '0;
            lrclk_q <= 1'b0;
            shift_q <= '0;
            und_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            shift_q <= shift_d;
            und_q   <= und_d;
            full_q  <= full_d;
        end
    end

    // Holding-buffer payload is only meaningful while full_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_l_q <= i_left;
            buf_r_q <= i_right;
        end
    end

    assign o_ready    = ~full_q;
    assign o_bclk     = bclk_q;
    assign o_lrclk    = lrclk_q;
    assign o_din      = shift_q[FRAME_W-1];
    assign o_underrun = und_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: time-based frame model checked every cycle, an I2S
// decoder on the serial pins, and a second instance measuring CLK_DIV=49 timing.
`timescale 1ns/1ps

module tb_i2s_transmitter;

    localparam int D   = 2;
    localparam int D49 = 49;

    logic        clk = 1'b0;
    logic        rst, rst49;
    logic [15:0] i_left, i_right, l49, r49;
    logic        i_valid, v49;
    logic        o_ready, o_bclk, o_lrclk, o_din, o_underrun;
    logic        rdy49, b49, lr49, din49, und49;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    i2s_transmitter #(.CLK_DIV(D), .SAMPLE_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i_left(i_left), .i_right(i_right), .i_valid(i_valid),
        .o_ready(o_ready), .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_din(o_din),
        .o_underrun(o_underrun)
    );

    i2s_transmitter #(.CLK_DIV(D49), .SAMPLE_WIDTH(16)) dut49 (
        .clk(clk), .rst(rst49), .i_left(l49), .i_right(r49), .i_valid(v49),
        .o_ready(rdy49), .o_bclk(b49), .o_lrclk(lr49), .o_din(din49),
        .o_underrun(und49)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: everything is a function of clocks since reset release plus the list of loaded frames.
    int          m_t = 0;
    int          m_n = 0;
    int          m_fc = 0;
    bit          m_pend = 0;
    bit          m_und = 0;
    logic [31:0] m_pair = '0;
    logic [31:0] frames [0:255];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_t = 0; m_fc = 0; m_pend = 0; m_und = 0;
        end else begin
            m_n   = m_t + 1;
            m_und = 0;
            if ((m_n % (2*D)) == 0 && ((m_n / (2*D)) % 32) == 1) begin
                if (m_pend) begin
                    frames[m_fc % 256] = m_pair;
                    m_pend = 0;
                end else if (i_valid) begin
                    frames[m_fc % 256] = {i_left, i_right};
                end else begin
                    frames[m_fc % 256] = 32'h0;
                    m_und = 1;
                end
                m_fc++;
            end else if (i_valid && !m_pend) begin
                m_pend = 1;
                m_pair = {i_left, i_right};
            end
            m_t = m_n;
        end
    end

    int         e_f;
    logic [4:0] e_vec;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_f      = m_t / (2*D);
            e_vec[4] = ((m_t / D) % 2) == 1;
            e_vec[3] = (e_f % 32) >= 16;
            e_vec[2] = (e_f == 0) ? 1'b0 : frames[((e_f - 1) / 32) % 256][31 - ((e_f - 1) % 32)];
            e_vec[1] = !m_pend;
            e_vec[0] = m_und;
            check("cycle_bclk_lr_din_rdy_und",
                  32'({o_bclk, o_lrclk, o_din, o_ready, o_underrun}), 32'(e_vec));
        end
    end

    // Decoder: DIN sampled on BCLK rise; the bit taken when LRCLK flips is the old word's LSB.
    logic [16:0] dec_q [$];
    logic [15:0] d_sr = '0;
    logic        d_pb = 1'b0, d_pl = 1'b0;
    int          und_q [$];
    bit          rdy_hist [300];
    bit          din_one = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            dec_q.delete(); und_q.delete();
            d_sr = '0; d_pb = 1'b0; d_pl = 1'b0; din_one = 0;
        end else begin
            if (o_bclk && !d_pb) begin
                d_sr = {d_sr[14:0], o_din};
                if (o_lrclk != d_pl) dec_q.push_back({d_pl, d_sr});
                d_pl = o_lrclk;
            end
            d_pb = o_bclk;
            if (o_underrun) und_q.push_back(m_t);
            if (m_t < 300) rdy_hist[m_t] = o_ready;
            if (o_din) din_one = 1;
        end
    end

    function automatic logic [31:0] dec_at(input int i);
        return (i < dec_q.size()) ? 32'(dec_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] und_at(input int i);
        return (i < und_q.size()) ? 32'(und_q[i]) : 32'hFFFF_FFFF;
    endfunction

    // Timing monitor for the CLK_DIV=49 instance.
    int c49 = 0, last_rise = 0, last_lr = 0, lr_rises = 0, und49_cnt = 0;
    bit pb49 = 0, pl49 = 0, din49_one = 0;
    initial forever begin
        @(negedge clk);
        if (rst49) begin
            c49 = 0; last_rise = 0; last_lr = 0; lr_rises = 0; pb49 = 0; pl49 = 0;
        end else begin
            c49++;
            if (b49 && !pb49) begin
                if (last_rise == 0) check("bclk49_first_rise", 32'(c49), 32'd49);
                else                check("bclk49_period", 32'(c49 - last_rise), 32'd98);
                last_rise = c49;
            end
            if (!b49 && pb49) check("bclk49_high_time", 32'(c49 - last_rise), 32'd49);
            if (lr49 != pl49) begin
                check("lrclk49_on_bclk_fall", 32'({pb49, b49}), 32'b10);
                if (lr49) begin
                    if (lr_rises > 0) check("lrclk49_period", 32'(c49 - last_lr), 32'd3136);
                    else              check("lrclk49_first_rise", 32'(c49), 32'd1568);
                    last_lr = c49;
                    lr_rises++;
                end
            end
            if (und49) und49_cnt++;
            if (din49) din49_one = 1;
            pb49 = b49;
            pl49 = lr49;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bit rdy;
        bit done;
        done = 0;
        i_left = l; i_right = r; i_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            rdy = o_ready;
            @(negedge clk);
            done = rdy;
        end
        i_valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_t(input int t);
        for (int k = 0; k < 20000 && m_t < t; k++) @(negedge clk);
        check("wait_time_reached", 32'(m_t >= t), 32'd1);
    endtask

    task automatic wait_dec(input int n, input int bound);
        for (int k = 0; k < bound && dec_q.size() < n; k++) @(negedge clk);
        check("decoded_word_count", 32'(dec_q.size() >= n), 32'd1);
    endtask

    logic [15:0] nn;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_left = '0; i_right = '0;
        do_reset();

        // Idle after reset: silence and one underrun per 128-clk frame.
        check("reset_outputs", 32'({o_bclk, o_lrclk, o_din, o_underrun, o_ready}), 32'b00001);
        wait_t(1);
        check("bclk_low_t1", 32'(o_bclk), 32'd0);
        @(negedge clk);
        check("bclk_first_rise_t2", 32'(o_bclk), 32'd1);
        wait_t(400);
        @(negedge clk);
        check("idle_underrun_count", 32'(und_q.size()), 32'd4);
        check("idle_underrun_0", und_at(0), 32'd4);
        check("idle_underrun_1", und_at(1), 32'd132);
        check("idle_underrun_2", und_at(2), 32'd260);
        check("idle_underrun_3", und_at(3), 32'd388);
        check("idle_din_silent", 32'(din_one), 32'd0);

        // Single pair.
        do_reset();
        push(16'hA5C3, 16'h0F0F);
        wait_dec(2, 400);
        check("single_left", dec_at(0), 32'h0000_A5C3);
        check("single_right", dec_at(1), 32'h0001_0F0F);
        check("single_no_underrun_yet", 32'(und_q.size()), 32'd0);
        wait_t(140);
        check("single_next_frame_underrun", und_at(0), 32'd132);

        // Back-to-back stream of 8 pairs.
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            nn = 16'(n);
            push(nn, ~nn);
        end
        wait_dec(16, 1500);
        for (int n = 1; n <= 8; n++) begin
            nn = 16'(n);
            check("stream_left", dec_at(2*n - 2), {16'h0000, nn});
            check("stream_right", dec_at(2*n - 1), {16'h0001, ~nn});
        end
        check("stream_rdy_t1", 32'(rdy_hist[1]), 32'd0);
        check("stream_rdy_t4", 32'(rdy_hist[4]), 32'd1);
        check("stream_rdy_t5", 32'(rdy_hist[5]), 32'd0);
        check("stream_rdy_t132", 32'(rdy_hist[132]), 32'd1);
        check("stream_rdy_t133", 32'(rdy_hist[133]), 32'd0);
        wait_t(1030);
        check("stream_first_underrun", und_at(0), 32'd1028);

        // Bypass: valid only in the clock of the frame-1 load.
        do_reset();
        wait_t(131);
        i_left = 16'h8001; i_right = 16'h7FFE; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        wait_dec(4, 400);
        check("bypass_silent_left", dec_at(0), 32'h0000_0000);
        check("bypass_left", dec_at(2), 32'h0000_8001);
        check("bypass_right", dec_at(3), 32'h0001_7FFE);
        check("bypass_rdy_t132", 32'(rdy_hist[132]), 32'd1);
        check("bypass_rdy_t133", 32'(rdy_hist[133]), 32'd1);
        wait_t(262);
        check("bypass_underrun_0", und_at(0), 32'd4);
        check("bypass_underrun_1", und_at(1), 32'd260);

        // Asynchronous reset at slot 20 with a pair still buffered.
        do_reset();
        push(16'h1234, 16'h5678);
        push(16'h9ABC, 16'hDEF0);
        push(16'h1357, 16'h2468);
        wait_t(210);
        check("pre_rst_frame0_left", dec_at(0), 32'h0000_1234);
        check("pre_rst_frame0_right", dec_at(1), 32'h0001_5678);
        check("pre_rst_frame1_left", dec_at(2), 32'h0000_9ABC);
        check("pre_rst_state", 32'({o_bclk, o_lrclk, o_din, o_ready}), 32'b1110);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", 32'({o_bclk, o_lrclk, o_din, o_underrun, o_ready}), 32'b00001);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(16'hCAFE, 16'hBEEF);
        wait_dec(2, 400);
        check("post_rst_left", dec_at(0), 32'h0000_CAFE);
        check("post_rst_right", dec_at(1), 32'h0001_BEEF);
        wait_t(134);
        check("post_rst_buffer_discarded", und_at(0), 32'd132);

        // Let the CLK_DIV=49 instance cover several LRCLK periods.
        for (int k = 0; k < 20000 && lr_rises < 3; k++) @(negedge clk);
        check("lrclk49_periods_seen", 32'(lr_rises >= 3), 32'd1);
        check("dut49_idle_ready", 32'(rdy49), 32'd1);
        check("dut49_din_silent", 32'(din49_one), 32'd0);
        check("dut49_underruns_seen", 32'(und49_cnt > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst49 = 1'b1; v49 = 1'b0; l49 = '0; r49 = '0;
        repeat (3) @(negedge clk);
        rst49 = 1'b0;
    end

endmodule
